dds_modulator_v2: RTL and testbench
===================================

DDS_MODULATOR_V2 -- requirements
Module: dds_modulator_v2

Interface
REQ-001 The block SHALL have parameter PINC_BITS, default 16, phase-accumulator width of the downstream DDS.
REQ-002 The block SHALL have parameter PERIOD_BITS, default 16, width of the pulse timing counters.
REQ-003 The block SHALL have parameter CODE_LEN_MAX, default 32, maximum phase-code length in chips.
REQ-004 The block SHALL have parameter SUB_BITS, default 16, width of the subpulse-length field.
REQ-005 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk_i  in  1  single clock
- resetn_i  in  1  reset, asynchronous, active-low
- cfg_enable_i  in  1  run request (level)
- cfg_mode_i  in  3  0 CONT, 1 CONT_FM_SAW, 2 CONT_PM, 3 PULS, 4 PULS_FM_SAW, 5 PULS_PM, 6 CONT_FM_TRI, 7 PULS_FM_TRI
- cfg_pinc_lo_i  in  PINC_BITS  base/low phase increment
- cfg_pinc_hi_i  in  PINC_BITS  FM upper limit
- cfg_delta_i  in  PINC_BITS  FM step per beat
- cfg_pulse_i  in  PERIOD_BITS  pulse length, beats
- cfg_period_i  in  PERIOD_BITS  repetition period, beats
- cfg_burst_i  in  16  pulses per burst; 0 = infinite
- cfg_code_i  in  CODE_LEN_MAX  phase code, chip 0 = bit code_len-1
- cfg_code_len_i  in  6  active chips
- cfg_sub_i  in  SUB_BITS  beats per chip minus 1
- m_axis_modulation_tdata  out  2*PW  {POFF, PINC}, each zero-extended to PW = PINC_BITS rounded up to a multiple of 8
- m_axis_modulation_tvalid  out  1  beat valid
- m_axis_modulation_tready  in  1  downstream ready
- dds_en_o  out  1  DDS clock enable
- rf_gate_o  out  1  high while inside a pulse
- done_o  out  1  burst complete
- error_o  out  1  illegal configuration

Function
REQ-006 The block SHALL implement states IDLE, RUN and DONE.
REQ-007 IDLE->RUN SHALL occur on the cycle after cfg_enable_i is seen high with a legal configuration; all cfg_* are captured at that point.
REQ-008 In mode 0 only, cfg_pinc_lo_i SHALL additionally be sampled live, registered one cycle before use.
REQ-009 A configuration SHALL be illegal if period=0, pulse>period (pulsed modes), code_len=0 or >CODE_LEN_MAX (PM modes), or lo>hi (FM modes); an illegal configuration SHALL set error_o and keep the block in IDLE.
REQ-010 error_o SHALL clear when cfg_enable_i goes low.
REQ-011 cfg_enable_i low in any state SHALL return the block to IDLE on the next cycle, clearing done_o and the counters.
REQ-012 In RUN, tvalid and dds_en_o SHALL be 1; in IDLE and DONE both SHALL be 0.
REQ-013 The first beat SHALL appear one cycle after the IDLE->RUN transition.
REQ-014 The sequence SHALL advance only on tvalid&tready; when tready=0, tdata and all internal counters SHALL hold.
REQ-015 The FM saw SHALL start at lo and add delta per beat; if pinc+delta>hi, the next value SHALL be lo. The comparison SHALL use PINC_BITS+1 bits, with no wrap.
REQ-016 The FM triangle SHALL count up by delta; when the next value exceeds hi it SHALL clamp to hi and reverse. When counting down, a next value below lo SHALL clamp to lo and reverse.
REQ-017 In PM modes, PINC SHALL be lo; POFF SHALL be 0 for code bit 1 and 1<<(PINC_BITS-1) for code bit 0. Each chip lasts sub+1 beats, and chips wrap after code_len.
REQ-018 In pulsed modes, a period counter 0..period-1 SHALL advance per beat; rf_gate_o=1 while count<pulse. Outside the pulse, PINC and POFF SHALL be 0.
REQ-019 FM value, FM direction, and the chip/subpulse counters SHALL restart at each period start.
REQ-020 With burst≠0, the block SHALL go to DONE after the last beat of pulse number burst's period, and done_o SHALL be 1 until enable goes low. Continuous modes SHALL ignore burst.

Reset
REQ-021 While resetn_i=0, all state SHALL clear asynchronously: state=IDLE; tdata=0, tvalid=0, dds_en_o=0, rf_gate_o=0, done_o=0, error_o=0.
REQ-022 After resetn_i deasserts mid-run, the block SHALL restart from IDLE and require cfg_enable_i high to run again.

Verification (PINC_BITS=16, tready=1 unless stated)
REQ-023 Mode 0, lo=524, enable -> tvalid one cycle after RUN, PINC=524, POFF=0; change lo to 5243 -> new PINC within 2 beats.
REQ-024 Mode 6, lo=0, hi=100, delta=10 -> PINC 0,10,…,100,90,…,0,10,…; mode 1 with the same values -> 0,…,100,0,10.
REQ-025 Mode 2, code_len=5, code=5'b11101, sub=1 -> POFF per beat 0,0,0,0,0,0,8000h,8000h,0,0, repeating.
REQ-026 Mode 3, pulse=3, period=5, burst=2, lo=524 -> rf_gate 1,1,1,0,0,1,1,1,0,0, then done_o=1 and tvalid=0; enable low -> IDLE.
REQ-027 Mode 6 with tready low for 3 cycles mid-ramp -> tdata held, and the ramp resumes with no skipped or repeated value.
REQ-028 Mode 3 with pulse=6, period=5 -> error_o=1, tvalid stays 0; resetn_i pulsed mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/dds_modulator_v2.sv
// DDS modulation sequencer. Emits one {POFF, PINC} beat per handshake for CW,
// FM saw/triangle and binary phase-coded waveforms, optionally gated into
// pulses and counted bursts.
module dds_modulator_v2 #(
  parameter  int PINC_BITS    = 16,
  parameter  int PERIOD_BITS  = 16,
  parameter  int CODE_LEN_MAX = 32,
  parameter  int SUB_BITS     = 16,
  localparam int PW           = ((PINC_BITS + 7) / 8) * 8
) (
  input  logic                    clk_i,
  input  logic                    resetn_i,
  input  logic                    cfg_enable_i,
  input  logic [2:0]              cfg_mode_i,
  input  logic [PINC_BITS-1:0]    cfg_pinc_lo_i,
  input  logic [PINC_BITS-1:0]    cfg_pinc_hi_i,
  input  logic [PINC_BITS-1:0]    cfg_delta_i,
  input  logic [PERIOD_BITS-1:0]  cfg_pulse_i,
  input  logic [PERIOD_BITS-1:0]  cfg_period_i,
  input  logic [15:0]             cfg_burst_i,
  input  logic [CODE_LEN_MAX-1:0] cfg_code_i,
  input  logic [5:0]              cfg_code_len_i,
  input  logic [SUB_BITS-1:0]     cfg_sub_i,
  output logic [2*PW-1:0]         m_axis_modulation_tdata,
  output logic                    m_axis_modulation_tvalid,
  input  logic                    m_axis_modulation_tready,
  output logic                    dds_en_o,
  output logic                    rf_gate_o,
  output logic                    done_o,
  output logic                    error_o
);

  localparam logic [PERIOD_BITS-1:0] PER_ONE = 1;
  localparam logic [SUB_BITS-1:0]    SUB_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  typedef struct packed {
    logic [2:0]              mode;
    logic [PINC_BITS-1:0]    lo;
    logic [PINC_BITS-1:0]    hi;
    logic [PINC_BITS-1:0]    delta;
    logic [PERIOD_BITS-1:0]  pulse;
    logic [PERIOD_BITS-1:0]  period;
    logic [15:0]             burst;
    logic [CODE_LEN_MAX-1:0] code;
    logic [5:0]              code_len;
    logic [SUB_BITS-1:0]     sub;
  } cfg_t;

  // Position of the beat currently on the bus.
  typedef struct packed {
    logic [PERIOD_BITS-1:0] per;
    logic [PINC_BITS-1:0]   fm;
    logic                   dn;      // triangle counting down
    logic [SUB_BITS-1:0]    sub;
    logic [5:0]             chip;
    logic [15:0]            npulse;  // completed periods in this burst
  } cnt_t;

  function automatic logic is_pulsed(input logic [2:0] m);
    return m inside {3'd3, 3'd4, 3'd5, 3'd7};
  endfunction

  function automatic logic is_fm(input logic [2:0] m);
    return m inside {3'd1, 3'd4, 3'd6, 3'd7};
  endfunction

  function automatic logic is_tri(input logic [2:0] m);
    return m inside {3'd6, 3'd7};
  endfunction

  function automatic logic is_pm(input logic [2:0] m);
    return m inside {3'd2, 3'd5};
  endfunction

  function automatic logic legal(input cfg_t c);
    logic ok;
    ok = (c.period != '0);
    if (is_pulsed(c.mode) && (c.pulse > c.period)) ok = 1'b0;
    if (is_pm(c.mode) && ((c.code_len == '0) || (int'(c.code_len) > CODE_LEN_MAX))) ok = 1'b0;
    if (is_fm(c.mode) && (c.lo > c.hi)) ok = 1'b0;
    return ok;
  endfunction

  // Counter values at the start of every period (and of the run).
  function automatic cnt_t restart(input cfg_t c);
    cnt_t r;
    r    = '0;
    r.fm = c.lo;
    return r;
  endfunction

  function automatic logic in_gate(input cfg_t c, input cnt_t k);
    return !is_pulsed(c.mode) || (k.per < c.pulse);
  endfunction

  function automatic logic [2*PW-1:0] beat(input cfg_t c, input cnt_t k,
                                           input logic [PINC_BITS-1:0] live);
    logic [PINC_BITS-1:0]    pinc, poff;
    logic [CODE_LEN_MAX-1:0] sh;
    logic [5:0]              idx;
    idx  = c.code_len - 6'd1 - k.chip;  // chip 0 is the MSB of the active code
    sh   = c.code >> idx;
    pinc = c.lo;
    poff = '0;
    if (c.mode == 3'd0) pinc = live;
    if (is_fm(c.mode))  pinc = k.fm;
    if (is_pm(c.mode) && !sh[0]) poff = {1'b1, {(PINC_BITS-1){1'b0}}};
    if (!in_gate(c, k)) begin
      pinc = '0;
      poff = '0;
    end
    return {PW'(poff), PW'(pinc)};
  endfunction

  // Advance every counter by one beat; FM compares are one bit wider so they never wrap.
  function automatic cnt_t step(input cfg_t c, input cnt_t k);
    cnt_t               n;
    logic [PINC_BITS:0] up;
    n  = k;
    up = {1'b0, k.fm} + {1'b0, c.delta};
    if (is_tri(c.mode)) begin
      if (!k.dn) begin
        if (up >= {1'b0, c.hi}) begin
          n.fm = c.hi;
          n.dn = 1'b1;
        end else n.fm = up[PINC_BITS-1:0];
      end else begin
        if ({1'b0, k.fm} <= ({1'b0, c.lo} + {1'b0, c.delta})) begin
          n.fm = c.lo;
          n.dn = 1'b0;
        end else n.fm = k.fm - c.delta;
      end
    end else begin
      n.fm = (up > {1'b0, c.hi}) ? c.lo : up[PINC_BITS-1:0];
    end
    if (k.sub == c.sub) begin
      n.sub  = '0;
      n.chip = (k.chip == c.code_len - 6'd1) ? 6'd0 : k.chip + 6'd1;
    end else n.sub = k.sub + SUB_ONE;
    if (is_pulsed(c.mode)) begin
      if (k.per == c.period - PER_ONE) begin
        n        = restart(c);
        n.npulse = k.npulse + 16'd1;
      end else n.per = k.per + PER_ONE;
    end
    return n;
  endfunction

  state_e              state_q;
  cfg_t                cfg_q, cfg_in;
  cnt_t                cnt_q, cnt_d, cnt_start;
  logic [PINC_BITS-1:0] live_q;
  logic [2*PW-1:0]     tdata_q, tdata_d, tdata_start;
  logic                tvalid_q, dds_en_q, gate_q, done_q, error_q;
  logic                gate_d, gate_start, last_beat, cfg_ok;

  // Gather the configuration inputs and precompute first and next beats.
  always_comb begin
    cfg_in          = '0;
    cfg_in.mode     = cfg_mode_i;
    cfg_in.lo       = cfg_pinc_lo_i;
    cfg_in.hi       = cfg_pinc_hi_i;
    cfg_in.delta    = cfg_delta_i;
    cfg_in.pulse    = cfg_pulse_i;
    cfg_in.period   = cfg_period_i;
    cfg_in.burst    = cfg_burst_i;
    cfg_in.code     = cfg_code_i;
    cfg_in.code_len = cfg_code_len_i;
    cfg_in.sub      = cfg_sub_i;
    cfg_ok          = legal(cfg_in);
    cnt_start       = restart(cfg_in);
    tdata_start     = beat(cfg_in, cnt_start, live_q);
    gate_start      = in_gate(cfg_in, cnt_start);
    cnt_d           = step(cfg_q, cnt_q);
    tdata_d         = beat(cfg_q, cnt_d, live_q);
    gate_d          = in_gate(cfg_q, cnt_d);
    last_beat       = is_pulsed(cfg_q.mode) && (cfg_q.burst != '0) &&
                      (cnt_q.per == cfg_q.period - PER_ONE) &&
                      (cnt_q.npulse == cfg_q.burst - 16'd1);
  end

  // Control FSM with registered beat outputs; enable low always wins.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q  <= S_IDLE;
      cfg_q    <= '0;
      cnt_q    <= '0;
      live_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      dds_en_q <= 1'b0;
      gate_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      live_q <= cfg_pinc_lo_i;
      if (!cfg_enable_i) begin
        state_q  <= S_IDLE;
        cnt_q    <= '0;
        tdata_q  <= '0;
        tvalid_q <= 1'b0;
        dds_en_q <= 1'b0;
        gate_q   <= 1'b0;
        done_q   <= 1'b0;
        error_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (cfg_ok) begin
              state_q  <= S_RUN;
              cfg_q    <= cfg_in;
              cnt_q    <= cnt_start;
              tdata_q  <= tdata_start;
              gate_q   <= gate_start;
              tvalid_q <= 1'b1;
              dds_en_q <= 1'b1;
              error_q  <= 1'b0;
            end else begin
              error_q <= 1'b1;
            end
          end
          S_RUN: begin
            if (m_axis_modulation_tready) begin
              if (last_beat) begin
                state_q  <= S_DONE;
                done_q   <= 1'b1;
                tvalid_q <= 1'b0;
                dds_en_q <= 1'b0;
                gate_q   <= 1'b0;
                tdata_q  <= '0;
              end else begin
                cnt_q   <= cnt_d;
                tdata_q <= tdata_d;
                gate_q  <= gate_d;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign m_axis_modulation_tdata  = tdata_q;
  assign m_axis_modulation_tvalid = tvalid_q;
  assign dds_en_o                 = dds_en_q;
  assign rf_gate_o                = gate_q;
  assign done_o                   = done_q;
  assign error_o                  = error_q;

endmodule

// File: tb/tb_dds_modulator_v2.sv
// Randomised bench for dds_modulator_v2 checked against a closed-form beat model.
module tb_dds_modulator_v2;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        en = 1'b0, rdy = 1'b0;
  logic [2:0]  mode = '0;
  logic [15:0] lo = '0, hi = '0, delta = '0, pulse = '0, period = '0, burst = '0;
  logic [31:0] code = '0;
  logic [5:0]  clen = '0;
  logic [15:0] sub = '0;
  logic [31:0] tdata;
  logic        tvalid, dds_en, gate, done, err;

  int total = 0, bad = 0;

  // model configuration
  int          m_mode, m_lo, m_pulse, m_period, m_clen, m_sub;
  logic [31:0] m_code;
  int          fm_tab[$];

  dds_modulator_v2 dut (
    .clk_i(clk), .resetn_i(rstn), .cfg_enable_i(en), .cfg_mode_i(mode),
    .cfg_pinc_lo_i(lo), .cfg_pinc_hi_i(hi), .cfg_delta_i(delta),
    .cfg_pulse_i(pulse), .cfg_period_i(period), .cfg_burst_i(burst),
    .cfg_code_i(code), .cfg_code_len_i(clen), .cfg_sub_i(sub),
    .m_axis_modulation_tdata(tdata), .m_axis_modulation_tvalid(tvalid),
    .m_axis_modulation_tready(rdy), .dds_en_o(dds_en), .rf_gate_o(gate),
    .done_o(done), .error_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_pulsed(input int m); return m == 3 || m == 4 || m == 5 || m == 7; endfunction
  function automatic bit m_fm(input int m);     return m == 1 || m == 4 || m == 6 || m == 7; endfunction
  function automatic bit m_pm(input int m);     return m == 2 || m == 5; endfunction

  // One full FM cycle as a list of values, built straight from the ramp rules.
  task automatic build_fm(input int md, input int l, input int h, input int d);
    fm_tab.delete();
    if (md == 6 || md == 7) begin
      for (int v = l; v < h; v += d) fm_tab.push_back(v);
      fm_tab.push_back(h);
      for (int v = h - d; v > l; v -= d) fm_tab.push_back(v);
    end else begin
      for (int v = l; v <= h; v += d) fm_tab.push_back(v);
    end
  endtask

  // Expected {gate, POFF, PINC} of beat k counted from the start of the run.
  function automatic logic [32:0] exp_beat(input int k);
    int j, pinc, poff, chip;
    bit g;
    j    = m_pulsed(m_mode) ? k % m_period : k;
    g    = !m_pulsed(m_mode) || (j < m_pulse);
    pinc = m_lo;
    poff = 0;
    if (m_fm(m_mode)) pinc = fm_tab[j % fm_tab.size()];
    if (m_pm(m_mode)) begin
      chip = (j / (m_sub + 1)) % m_clen;
      if (m_code[m_clen - 1 - chip] == 1'b0) poff = 32768;
    end
    if (!g) begin
      pinc = 0;
      poff = 0;
    end
    return {g, poff[15:0], pinc[15:0]};
  endfunction

  task automatic set_cfg(input int md, input int l, input int h, input int d, input int pu,
                         input int pe, input int bu, input logic [31:0] cd, input int cl, input int sb);
    mode = md[2:0]; lo = l[15:0]; hi = h[15:0]; delta = d[15:0];
    pulse = pu[15:0]; period = pe[15:0]; burst = bu[15:0];
    code = cd; clen = cl[5:0]; sub = sb[15:0];
    m_mode = md; m_lo = l; m_pulse = pu; m_period = pe; m_code = cd; m_clen = cl; m_sub = sb;
    if (m_fm(md)) build_fm(md, l, h, d);
  endtask

  task automatic run_cfg(input string nm, input int md, input int l, input int h, input int d,
                         input int pu, input int pe, input int bu, input logic [31:0] cd,
                         input int cl, input int sb, input int nbeats, input int rdy_pct);
    int k, cyc, target;
    logic [32:0] e;
    bit burst_run;
    set_cfg(md, l, h, d, pu, pe, bu, cd, cl, sb);
    burst_run = m_pulsed(md) && (bu != 0);
    target    = burst_run ? bu * pe : nbeats;
    k = 0;
    cyc = 0;
    @(posedge clk); #1 en = 1'b1;
    while (k < target && cyc < 20 * target + 50) begin
      @(posedge clk); #1 rdy = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      if (tvalid && rdy) begin
        e = exp_beat(k);
        chk({nm, ".tdata"}, tdata, e[31:0]);
        chk({nm, ".gate"}, gate, e[32]);
        chk({nm, ".dds_en"}, dds_en, 1);
        k++;
      end
      cyc++;
    end
    chk({nm, ".beats"}, k, target);
    if (burst_run) begin
      @(posedge clk); @(negedge clk);
      chk({nm, ".done"}, {done, tvalid, dds_en}, 3'b100);
    end
    @(posedge clk); #1 en = 1'b0;
    @(posedge clk); @(negedge clk);
    chk({nm, ".idle"}, {done, tvalid, dds_en, gate}, 4'b0000);
    rdy = 1'b1;
  endtask

  initial begin
    int n;
    int r_md, r_hi, r_lo;
    // reset state
    #23;
    chk("reset.outs", {tdata, tvalid, dds_en, gate, done, err}, '0);
    @(negedge clk) rstn = 1'b1;
    rdy = 1'b1;

    // mode 0: latency, live low increment
    set_cfg(0, 524, 0, 0, 0, 1, 0, 0, 1, 0);
    @(posedge clk); @(posedge clk); #1 en = 1'b1;
    chk("m0.pre_valid", tvalid, 0);
    @(posedge clk); #1;
    chk("m0.valid", {tvalid, dds_en}, 2'b11);
    chk("m0.first", tdata, 32'd524);
    lo = 16'd5243;
    @(posedge clk); @(posedge clk); #1;
    chk("m0.live", tdata, 32'd5243);
    en = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("m0.idle", tvalid, 0);

    // directed waveforms
    run_cfg("tri",   6, 0, 100, 10, 0, 1, 0, 32'h0, 1, 0, 45, 100);
    run_cfg("saw",   1, 0, 100, 10, 0, 1, 0, 32'h0, 1, 0, 25, 100);
    run_cfg("pm",    2, 300, 0, 0, 0, 1, 0, 32'b11101, 5, 1, 30, 100);
    run_cfg("puls",  3, 524, 0, 0, 3, 5, 2, 32'h0, 1, 0, 0, 100);
    run_cfg("tri_bp", 6, 0, 100, 10, 0, 1, 0, 32'h0, 1, 0, 40, 60);
    run_cfg("ptri",  7, 40, 200, 30, 4, 7, 3, 32'h0, 1, 0, 0, 80);

    // illegal configurations
    for (int t = 0; t < 5; t++) begin
      case (t)
        0: set_cfg(3, 0, 0, 0, 6, 5, 0, 0, 1, 0);
        1: set_cfg(0, 5, 0, 0, 0, 0, 0, 0, 1, 0);
        2: set_cfg(2, 5, 0, 0, 0, 4, 0, 0, 0, 0);
        3: set_cfg(1, 50, 40, 1, 0, 4, 0, 0, 1, 0);
        default: set_cfg(5, 5, 0, 0, 2, 4, 0, 0, 33, 0);
      endcase
      @(posedge clk); #1 en = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk($sformatf("illegal%0d.err", t), {err, tvalid, dds_en}, 3'b100);
      @(posedge clk); #1 en = 1'b0;
      @(posedge clk); @(negedge clk);
      chk($sformatf("illegal%0d.clr", t), err, 0);
    end

    // random configurations
    for (int t = 0; t < 14; t++) begin
      r_md = $urandom_range(7);
      if ($urandom_range(1) == 1) r_hi = $urandom_range(65535, 62000);
      else                        r_hi = $urandom_range(3000);
      r_lo = r_hi - $urandom_range((r_hi < 2000) ? r_hi : 2000);
      begin
        int pe;
        pe = $urandom_range(1, 10);
        run_cfg($sformatf("rnd%0d_m%0d", t, r_md), r_md, r_lo, r_hi, $urandom_range(1, 1500),
                $urandom_range(0, pe), pe, $urandom_range(0, 3), $urandom, $urandom_range(1, 32),
                $urandom_range(0, 3), 40, $urandom_range(50, 100));
      end
    end

    // asynchronous reset in the middle of a run
    set_cfg(6, 0, 100, 10, 0, 1, 0, 0, 1, 0);
    @(posedge clk); #1 en = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("rst.pre_valid", tvalid, 1);
    #1 rstn = 1'b0;
    #1 chk("rst.outs", {tdata, tvalid, dds_en, gate, done, err}, '0);
    @(negedge clk) rstn = 1'b1;
    n = 0;
    while (!tvalid && n < 5) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst.relaunch", n, 1);
    chk("rst.first", tdata, 32'd0);
    en = 1'b0;
    @(posedge clk); @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
